serial_sub: RTL and testbench

Parametrised multi-cycle subtractor built from a chain of full-subtractor cells. It computes `a - b - bi` over `WIDTH` bits, processing `BPC` bits per clock with a registered borrow between cycles. It sits wherever a wide subtract is needed with a small area budget, trading latency for cell count. A start/busy/done handshake controls it.

---
 rtl/serial_sub_pkg.sv | 18 +
 rtl/serial_sub_full_sub_cell.sv | 13 +
 rtl/serial_sub.sv | 177 +++++++++++++++++
 tb/tb_serial_sub.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and elaboration helpers for the serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int serial_sub_steps(input int width, input int bpc);
    return width / bpc;
  endfunction

  function automatic int serial_sub_cnt_w(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/serial_sub_full_sub_cell.sv
// Combinational single-bit full subtractor: d = a - b - bi, bo = borrow out.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~a & bi) | (b & bi);

endmodule

// File: rtl/serial_sub.sv
// Multi-cycle subtractor: a - b - bi over WIDTH bits, BPC bits per clock.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             bo
);

  localparam int N     = serial_sub_steps(WIDTH, BPC);
  localparam int CNT_W = serial_sub_cnt_w(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_cfg
    $error("serial_sub: WIDTH must be >= 2 and divisible by BPC");
  end

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bo_q, bo_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic             ovf_q, ovf_d;
`endif

  logic [BPC:0]     chain;
  logic [BPC-1:0]   step_diff;
  logic [WIDTH-1:0] step_ext;
  logic [WIDTH-1:0] acc_shift;

  // Borrow ripples through BPC cells, seeded by the inter-cycle borrow register.
  assign chain[0] = brw_q;
  for (genvar i = 0; i < BPC; i++) begin : g_cell
    full_sub_cell u_cell (
      .a  (opa_q[i]),
      .b  (opb_q[i]),
      .bi (chain[i]),
      .d  (step_diff[i]),
      .bo (chain[i+1])
    );
  end

  always_comb begin
    step_ext            = '0;
    step_ext[BPC-1:0]   = step_diff;
    acc_shift           = (acc_q >> BPC) | (step_ext << (WIDTH - BPC));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      brw_q   <= 1'b0;
      acc_q   <= '0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      brw_q   <= brw_d;
      acc_q   <= acc_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
`ifdef SERIAL_SUB_OVF_EN
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy/done are registered from the next state so outputs never decode inputs.
  always_comb begin
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_comb begin
    cnt_d  = cnt_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
    brw_d  = brw_q;
    acc_d  = acc_q;
    diff_d = diff_q;
    bo_d   = bo_q;
`ifdef SERIAL_SUB_OVF_EN
    amsb_d = amsb_q;
    bmsb_d = bmsb_q;
    ovf_d  = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d  = '0;
          opa_d  = a;
          opb_d  = b;
          brw_d  = bi;
          acc_d  = '0;
`ifdef SERIAL_SUB_OVF_EN
          amsb_d = a[WIDTH-1];
          bmsb_d = b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        opa_d = opa_q >> BPC;
        opb_d = opb_q >> BPC;
        brw_d = chain[BPC];
        acc_d = acc_shift;
        // Result is published only on the last step so d/bo stay frozen during RUN.
        if (cnt_q == LAST) begin
          diff_d = acc_shift;
          bo_d   = chain[BPC];
`ifdef SERIAL_SUB_OVF_EN
          ovf_d  = (amsb_q != bmsb_q) && (acc_shift[WIDTH-1] != amsb_q);
`endif
        end
      end
      default: ;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = diff_q;
  assign bo   = bo_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: four instances (BPC = 1, 2, 4, 8) share one stimulus bus.
module tb_serial_sub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         bi = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic         busy_v [4];
  logic         done_v [4];
  logic [W-1:0] d_v    [4];
  logic         bo_v   [4];
  logic         ovf_v  [4];

  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  bit           hold_mode = 1'b0;
  logic [9:0]   hold_exp = '0;
  logic [9:0]   sbq [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: {ovf, bo, d} from a 9-bit unsigned subtraction.
  function automatic logic [9:0] model(input logic [7:0] av, input logic [7:0] bv, input logic biv);
    logic [8:0] r;
    r = {1'b0, av} - {1'b0, bv} - {8'd0, biv};
    return {(av[7] != bv[7]) && (r[7] != av[7]), r};
  endfunction

  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam int BPCK = 1 << k;
    localparam int NK   = W / BPCK;

    serial_sub #(.WIDTH(W), .BPC(BPCK)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bi    (bi),
      .busy  (busy_v[k]),
      .done  (done_v[k]),
      .d     (d_v[k]),
`ifdef SERIAL_SUB_OVF_EN
      .ovf   (ovf_v[k]),
`endif
      .bo    (bo_v[k])
    );

`ifndef SERIAL_SUB_OVF_EN
    assign ovf_v[k] = 1'b0;
`endif

    int         rd = 0;
    int         rise_cyc = 0;
    bit         seen = 1'b0;
    logic       bprev = 1'b0;
    logic [9:0] e;

    always begin
      @(posedge clk);
      #1;
      if (rst) begin
        rd    = sbq.size();
        bprev = 1'b0;
        seen  = 1'b0;
      end else begin
        if (done_v[k]) begin
          check("busy_with_done", 32'(busy_v[k]), 32'd0);
          check("latency", 32'(cyc - rise_cyc), 32'(NK));
          if (hold_mode) begin
            e = hold_exp;
          end else if (rd >= sbq.size()) begin
            check("unexpected_done", 32'(rd), 32'(sbq.size()));
            e = {1'b0, bo_v[k], d_v[k]};
          end else begin
            e = sbq[rd];
            rd++;
          end
          check("d", 32'(d_v[k]), 32'(e[7:0]));
          check("bo", 32'(bo_v[k]), 32'(e[8]));
`ifdef SERIAL_SUB_OVF_EN
          check("ovf", 32'(ovf_v[k]), 32'(e[9]));
`endif
        end
        if (busy_v[k] && !bprev) begin
          if (hold_mode && seen) check("hold_interval", 32'(cyc - rise_cyc), 32'(NK + 2));
          rise_cyc = cyc;
          seen     = hold_mode;
        end
        bprev = busy_v[k];
      end
    end
  end

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic biv, input bit poke);
    int         t;
    logic [8:0] held;
    @(negedge clk);
    held  = {bo_v[0], d_v[0]};
    a     = av;
    b     = bv;
    bi    = biv;
    start = 1'b1;
    sbq.push_back(model(av, bv, biv));
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    bi    = 1'($urandom);
    check("busy_rise", 32'(busy_v[0]), 32'd1);
    t = 0;
    while (!done_v[0] && t < 40) begin
      if (poke && t == 1) begin
        start = 1'b1;
        a     = ~av;
        b     = ~bv;
      end
      if (poke && t == 2) start = 1'b0;
      if (busy_v[0]) check("out_hold", 32'({bo_v[0], d_v[0]}), 32'(held));
      @(posedge clk);
      #1;
      t++;
    end
    check("done_seen", 32'(done_v[0]), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("rst_busy", 32'(busy_v[k]), 32'd0);
      check("rst_done", 32'(done_v[k]), 32'd0);
      check("rst_d", 32'(d_v[k]), 32'd0);
      check("rst_bo", 32'(bo_v[k]), 32'd0);
      check("rst_ovf", 32'(ovf_v[k]), 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op(8'h05, 8'h03, 1'b0, 1'b0);
    run_op(8'h00, 8'h01, 1'b0, 1'b0);
    run_op(8'h00, 8'hFF, 1'b1, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0);
    run_op(8'hA5, 8'h5A, 1'b1, 1'b0);
    run_op(8'h37, 8'h12, 1'b0, 1'b1);

    // Abort mid-operation after three steps of the BPC=1 instance.
    @(negedge clk);
    a     = 8'h9C;
    b     = 8'h21;
    bi    = 1'b0;
    start = 1'b1;
    sbq.push_back(model(8'h9C, 8'h21, 1'b0));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy_v[0]), 32'd0);
    check("abort_done", 32'(done_v[0]), 32'd0);
    check("abort_d", 32'(d_v[0]), 32'd0);
    check("abort_bo", 32'(bo_v[0]), 32'd0);
    check("abort_busy_bpc2", 32'(busy_v[1]), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("no_done_after_abort", 32'(done_v[0]), 32'd0);
    end
    run_op(8'h9C, 8'h21, 1'b0, 1'b0);

    // start held high: back-to-back accepts, same operands every time.
    hold_exp  = model(8'h3C, 8'hC3, 1'b0);
    hold_mode = 1'b1;
    @(negedge clk);
    a     = 8'h3C;
    b     = 8'hC3;
    bi    = 1'b0;
    start = 1'b1;
    repeat (3 * (W + 2) + 1) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (W + 4) @(posedge clk);
    @(negedge clk);
    hold_mode = 1'b0;

    run_op(8'h80, 8'h01, 1'b0, 1'b0);
    run_op(8'h7F, 8'hFF, 1'b0, 1'b0);
    run_op(8'h10, 8'h01, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    end

    check("drain_bpc1", 32'(g_dut[0].rd), 32'(sbq.size()));
    check("drain_bpc2", 32'(g_dut[1].rd), 32'(sbq.size()));
    check("drain_bpc4", 32'(g_dut[2].rd), 32'(sbq.size()));
    check("drain_bpc8", 32'(g_dut[3].rd), 32'(sbq.size()));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
